// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU request/response and word-RAM signals bundled for the load/store unit
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  is_store;
    logic [1:0]            size;
    logic                  sign_extend;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           store_data;
    logic                  busy;
    logic                  done;
    logic [31:0]           load_data;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [31:0]           ram_data_in;
    logic                  ram_write_enable;
    logic [31:0]           ram_read_data;

    modport slave (
        input  req, is_store, size, sign_extend, address, store_data, ram_read_data,
        output busy, done, load_data, misaligned, ram_address, ram_data_in, ram_write_enable
    );

    modport master (
        output req, is_store, size, sign_extend, address, store_data, ram_read_data,
        input  busy, done, load_data, misaligned, ram_address, ram_data_in, ram_write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word CPU accesses to a word-only RAM, sub-word stores via read-modify-write.
// Define LSU_ALIGN_CHECK_EN to flag misaligned accesses instead of forcing their low address bits to zero.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter bit WORD_ADDRESSED = 1'b1
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    load_store_unit_if.slave     bus_io
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e                state_q, state_d;
    logic                  is_store_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [31:0]           word_q;
    logic [31:0]           load_q;
    logic                  mis_q;

    logic                  mis_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [31:0]           lane_mask;
    logic [31:0]           lane_data;
    logic [31:0]           merged;
    logic [31:0]           shifted;
    logic [31:0]           extended;

    // Qualify the incoming address: flag it when checking, otherwise silently align it
    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        mis_in  = (bus_io.size == 2'b01 && bus_io.address[0]) || (bus_io.size[1] && bus_io.address[1:0] != 2'b00);
        addr_in = bus_io.address;
`else
        mis_in  = 1'b0;
        addr_in = {bus_io.address[ADDR_WIDTH-1:2],
                   bus_io.address[1:0] & (bus_io.size[1] ? 2'b00 : bus_io.size[0] ? 2'b10 : 2'b11)};
`endif
    end

    // Sequencing: word stores skip READ, sub-word stores read first, misaligned goes straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus_io.req) state_d = mis_in ? DONE : (bus_io.is_store && bus_io.size[1]) ? WRITE : READ;
            READ:    state_d = is_store_q ? WRITE : DONE;
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, RAM word capture and load result hold
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            word_q     <= '0;
            load_q     <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus_io.req) begin
                is_store_q <= bus_io.is_store;
                size_q     <= bus_io.size;
                sign_q     <= bus_io.sign_extend;
                addr_q     <= addr_in;
                data_q     <= bus_io.store_data;
                mis_q      <= mis_in;
            end
            if (state_q == READ) word_q <= bus_io.ram_read_data;
            if (state_q == DONE) load_q <= bus_io.load_data;
        end
    end

    // Lane merge for stores and lane extraction/extension for loads; size 11 behaves as a word
    always_comb begin
        lane_mask = size_q[1] ? 32'hFFFF_FFFF : size_q[0] ? 32'h0000_FFFF << {addr_q[1], 4'b0000}
                                                           : 32'h0000_00FF << {addr_q[1:0], 3'b000};
        lane_data = size_q[1] ? data_q : size_q[0] ? {2{data_q[15:0]}} : {4{data_q[7:0]}};
        merged    = (word_q & ~lane_mask) | (lane_data & lane_mask);
        shifted   = word_q >> {addr_q[1:0], 3'b000};
        extended  = size_q[1] ? word_q : size_q[0] ? {{16{sign_q & shifted[15]}}, shifted[15:0]}
                                                   : {{24{sign_q & shifted[7]}}, shifted[7:0]};
    end

    // Bus outputs; the load result appears in the DONE cycle and is then held
    always_comb begin
        bus_io.busy             = state_q != IDLE;
        bus_io.done             = state_q == DONE;
        bus_io.misaligned       = state_q == DONE && mis_q;
        bus_io.ram_write_enable = state_q == WRITE;
        bus_io.ram_data_in      = state_q == WRITE ? merged : 32'h0;
        bus_io.ram_address      = WORD_ADDRESSED ? addr_q >> 2 : {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus_io.load_data        = (state_q == DONE && !is_store_q && !mis_q) ? extended : load_q;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized load/store traffic scored against a byte-level memory model
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus();
    load_store_unit #(.ADDR_WIDTH(32), .WORD_ADDRESSED(1'b1)) dut (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus));

    typedef struct {
        int          id;
        logic [31:0] ld;
        logic        mis;
        int          lat;
        int          writes;
        int          issue;
    } exp_t;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_load = 32'h0;
    exp_t        sb [$];
    exp_t        mon_e;
    int          cycle = 0;
    int          we_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          next_id = 0;

    assign bus.ram_read_data = mem[bus.ram_address[7:0]];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (bus.ram_write_enable) mem[bus.ram_address[7:0]] <= bus.ram_data_in;
    end

    always @(negedge clk) begin
        if (bus.ram_write_enable) we_cnt++;
        if (rst_n && bus.done) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done got done=1 expected no pending access");
            end else begin
                mon_e = sb.pop_front();
                if (bus.load_data !== mon_e.ld || bus.misaligned !== mon_e.mis ||
                    cycle - mon_e.issue != mon_e.lat || we_cnt != mon_e.writes) begin
                    miscompares++;
                    $display("FAIL access_%0d got ld=%h mis=%0b lat=%0d wr=%0d expected ld=%h mis=%0b lat=%0d wr=%0d",
                             mon_e.id, bus.load_data, bus.misaligned, cycle - mon_e.issue, we_cnt,
                             mon_e.ld, mon_e.mis, mon_e.lat, mon_e.writes);
                end
            end
            we_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input logic st, input logic [1:0] sz, input logic sx, input logic [31:0] addr,
                         input logic [31:0] d, output exp_t e);
        logic [31:0] a, w, v;
        int k, idx;
        a = addr;
        e.id = next_id++;
        e.mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        if ((sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0)) begin
            e.mis = 1'b1;
            e.ld = ref_load;
            e.lat = 1;
            e.writes = 0;
            return;
        end
`else
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz[1]) a[1:0] = 2'd0;
`endif
        idx = int'(a[9:2]);
        k = int'(a[1:0]);
        w = ref_mem[idx];
        if (!st) begin
            if (sz == 2'd0) begin
                v = (w >> (8 * k)) & 32'hFF;
                if (sx && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = (w >> (8 * k)) & 32'hFFFF;
                if (sx && v[15]) v = v | 32'hFFFF_0000;
            end else v = w;
            ref_load = v;
            e.ld = v;
            e.lat = 2;
            e.writes = 0;
        end else begin
            if (sz[1]) w = d;
            else if (sz == 2'd1) w[8*k +: 16] = d[15:0];
            else w[8*k +: 8] = d[7:0];
            ref_mem[idx] = w;
            e.ld = ref_load;
            e.lat = sz[1] ? 2 : 3;
            e.writes = 1;
        end
    endtask

    task automatic access(input logic st, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                          input logic [31:0] d);
        exp_t e;
        bit got;
        model(st, sz, sx, a, d, e);
        e.issue = cycle;
        sb.push_back(e);
        bus.req = 1'b1;
        bus.is_store = st;
        bus.size = sz;
        bus.sign_extend = sx;
        bus.address = a;
        bus.store_data = d;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            bus.req = 1'($urandom_range(0, 1));
            bus.is_store = 1'($urandom_range(0, 1));
            bus.size = 2'($urandom_range(0, 3));
            bus.address = $urandom;
            bus.store_data = $urandom;
            if (bus.done) got = 1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%0d got no done expected done within 8 cycles", e.id);
            sb.delete();
        end
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        bus.req = 1'b0;
        bus.is_store = 1'b0;
        bus.size = 2'b00;
        bus.sign_extend = 1'b0;
        bus.address = 32'h0;
        bus.store_data = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_load_data", bus.load_data, 32'h0);
        chk("rst_write_enable", {31'h0, bus.ram_write_enable}, 32'h0);
        chk("rst_ram_address", bus.ram_address, 32'h0);
        chk("rst_ram_data_in", bus.ram_data_in, 32'h0);
        chk("rst_misaligned", {31'h0, bus.misaligned}, 32'h0);

        access(1'b1, 2'b10, 1'b0, 32'h8, 32'h1509_0002);
        chk("word_store_ram", mem[2], 32'h1509_0002);
        access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        chk("word_load", bus.load_data, 32'h1509_0002);
        access(1'b1, 2'b00, 1'b0, 32'hA, 32'h0000_00AB);
        chk("byte_rmw_ram", mem[2], 32'h15AB_0002);
        access(1'b0, 2'b00, 1'b1, 32'hA, 32'h0);
        chk("byte_load_sx", bus.load_data, 32'hFFFF_FFAB);
        access(1'b0, 2'b00, 1'b0, 32'hA, 32'h0);
        chk("byte_load_zx", bus.load_data, 32'h0000_00AB);
        access(1'b1, 2'b10, 1'b0, 32'h8, 32'h8001_7FFF);
        access(1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
        chk("half_load_hi_sx", bus.load_data, 32'hFFFF_8001);
        access(1'b0, 2'b01, 1'b1, 32'h8, 32'h0);
        chk("half_load_lo", bus.load_data, 32'h0000_7FFF);
        access(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678);
        access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        access(1'b1, 2'b01, 1'b0, 32'h3, 32'hBEEF_CAFE);
        access(1'b0, 2'b11, 1'b1, 32'h4, 32'h0);

        bus.req = 1'b1;
        bus.is_store = 1'b1;
        bus.size = 2'b00;
        bus.address = 32'h9;
        bus.store_data = 32'h0000_005A;
        @(negedge clk);
        bus.req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
        chk("midrst_done", {31'h0, bus.done}, 32'h0);
        rst_n = 1'b1;
        ref_load = 32'h0;
        repeat (3) @(negedge clk);
        chk("midrst_no_write", we_cnt, 0);
        chk("midrst_ram", mem[2], ref_mem[2]);
        chk("midrst_load_data", bus.load_data, 32'h0);

        for (int n = 0; n < 300; n++)
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 1023)), $urandom);

        chk("scoreboard_drained", sb.size(), 0);
        for (int i = 0; i < 256; i++) begin
            vectors++;
            if (mem[i] !== ref_mem[i]) begin
                miscompares++;
                $display("FAIL ram_word_%0d got %h expected %h", i, mem[i], ref_mem[i]);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
